// File: rtl/pc_unit_pkg.sv
// ---------------------------------------------------------------------------
// pc_pkg
// Shared types and constants for the program-counter unit.
//   state_e    : sequencing state of the PC unit (BOOT, RUN, TRAP)
//   pc_src_e   : next-PC source select driven by the core FSM
//   CAUSE_MISALIGNED : cause code recorded for a misaligned control transfer
// ---------------------------------------------------------------------------
package pc_pkg;

    // Sequencing state of the PC unit. BOOT is the single stall cycle after
    // reset, TRAP is the single redirect cycle to the trap vector.
    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        TRAP = 2'd2
    } state_e;

    // Next-PC source selection, encoded as the core FSM drives it.
    typedef enum logic [1:0] {
        PC_SEQ    = 2'd0,
        PC_TARGET = 2'd1,
        PC_JALR   = 2'd2,
        PC_MRET   = 2'd3
    } pc_src_e;

    localparam int CAUSE_MISALIGNED = 0;

endpackage

// File: rtl/pc_unit_if.sv
// ---------------------------------------------------------------------------
// pc_unit_if
// Control/status bundle between the core FSM (master) and the PC unit
// (slave).
//   master -> slave : pc_write, pc_src, target, ir_write, trap_req, trap_cause
//   slave -> master : pc, old_pc, pc_plus, epc, cause, trap_taken, busy
// ---------------------------------------------------------------------------
interface pc_unit_if
    import pc_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int CAUSE_W = 4
);

    logic                pc_write;
    pc_src_e             pc_src;
    logic [XLEN-1:0]     target;
    logic                ir_write;
    logic                trap_req;
    logic [CAUSE_W-1:0]  trap_cause;

    logic [XLEN-1:0]     pc;
    logic [XLEN-1:0]     old_pc;
    logic [XLEN-1:0]     pc_plus;
    logic [XLEN-1:0]     epc;
    logic [CAUSE_W-1:0]  cause;
    logic                trap_taken;
    logic                busy;

    // The core FSM drives the controls and observes PC state.
    modport master (
        output pc_write, pc_src, target, ir_write, trap_req, trap_cause,
        input  pc, old_pc, pc_plus, epc, cause, trap_taken, busy
    );

    // The PC unit consumes the controls and publishes PC state.
    modport slave (
        input  pc_write, pc_src, target, ir_write, trap_req, trap_cause,
        output pc, old_pc, pc_plus, epc, cause, trap_taken, busy
    );

endinterface

// File: rtl/pc_unit_next_sel.sv
// ---------------------------------------------------------------------------
// pc_next_sel
// Combinational next-PC candidate selection and alignment check.
//   pc_i       : current PC
//   target_i   : ALU-computed target address
//   epc_i      : committed exception PC (MRET return address)
//   pc_src_i   : next-PC source select
//   pc_write_i : PC update request; a misaligned candidate only matters
//                when it would actually be written
//   nxt_o      : next-PC candidate
//   mis_o      : candidate is not IALIGN-aligned and a write is requested
// ---------------------------------------------------------------------------
module pc_next_sel
    import pc_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int IALIGN = 4
) (
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] target_i,
    input  logic [XLEN-1:0] epc_i,
    input  pc_src_e         pc_src_i,
    input  logic            pc_write_i,
    output logic [XLEN-1:0] nxt_o,
    output logic            mis_o
);

    // IALIGN is a power of two (2 or 4), so "mod IALIGN" reduces to masking
    // the low address bits.
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(IALIGN - 1);

    // Pick the candidate for the selected source. The sequential path wraps
    // silently at 2^XLEN; JALR clears bit 0 as the ISA requires.
    always_comb begin
        nxt_o = pc_i + XLEN'(IALIGN);
        case (pc_src_i)
            PC_SEQ:    nxt_o = pc_i + XLEN'(IALIGN);
            PC_TARGET: nxt_o = target_i;
            PC_JALR:   nxt_o = {target_i[XLEN-1:1], 1'b0};
            PC_MRET:   nxt_o = epc_i;
            default:   nxt_o = pc_i + XLEN'(IALIGN);
        endcase
    end

    assign mis_o = pc_write_i && ((nxt_o & ALIGN_MASK) != '0);

endmodule

// File: rtl/pc_unit.sv
// ---------------------------------------------------------------------------
// pc_unit
// Program-counter unit for the multicycle RV32I core. Holds the PC, the PC
// of the instruction in IR, and the trap state (EPC/cause). Sequences one
// BOOT cycle after reset and a one-cycle TRAP redirect to TRAP_VECTOR.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : pc_unit_if slave port
//         in  : pc_write, pc_src, target, ir_write, trap_req, trap_cause
//         out : pc, old_pc, pc_plus, epc, cause, trap_taken, busy
// ---------------------------------------------------------------------------
module pc_unit
    import pc_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100,
    parameter int              IALIGN       = 4,
    parameter int              CAUSE_W      = 4
) (
    input  logic     clk,
    input  logic     rst,
    pc_unit_if.slave bus
);

    state_e              state_q;
    logic [XLEN-1:0]     pc_q;
    logic [XLEN-1:0]     oldPc_q;
    logic [XLEN-1:0]     epc_q;
    logic [CAUSE_W-1:0]  cause_q;
    logic [XLEN-1:0]     epcN_q;
    logic [CAUSE_W-1:0]  causeN_q;
    logic                trapTaken_q;
    logic                busy_q;

    logic [XLEN-1:0]     nxt_d;
    logic                mis;

    pc_next_sel #(
        .XLEN   (XLEN),
        .IALIGN (IALIGN)
    ) uNextSel (
        .pc_i       (pc_q),
        .target_i   (bus.target),
        .epc_i      (epc_q),
        .pc_src_i   (bus.pc_src),
        .pc_write_i (bus.pc_write),
        .nxt_o      (nxt_d),
        .mis_o      (mis)
    );

    // Main sequencer. In RUN a trap is decided on the edge that samples it:
    // the EPC/cause candidates are parked in epcN_q/causeN_q and only
    // committed on the TRAP->RUN edge, so a reset during TRAP leaves the
    // architectural EPC/cause at their reset values. A misaligned transfer
    // outranks an external request and records the faulting instruction's
    // PC (old_pc), while an external request records the current PC.
    // trap_taken and busy are registered alongside the state so they change
    // exactly on state boundaries.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= BOOT;
            pc_q        <= RESET_VECTOR;
            oldPc_q     <= RESET_VECTOR;
            epc_q       <= '0;
            cause_q     <= '0;
            epcN_q      <= '0;
            causeN_q    <= '0;
            trapTaken_q <= 1'b0;
            busy_q      <= 1'b1;
        end else begin
            if ((state_q != BOOT) && bus.ir_write) begin
                oldPc_q <= pc_q;
            end
            case (state_q)
                BOOT: begin
                    state_q     <= RUN;
                    trapTaken_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
                RUN: begin
                    if (mis) begin
                        state_q     <= TRAP;
                        epcN_q      <= oldPc_q;
                        causeN_q    <= CAUSE_W'(CAUSE_MISALIGNED);
                        trapTaken_q <= 1'b1;
                        busy_q      <= 1'b1;
                    end else if (bus.trap_req) begin
                        state_q     <= TRAP;
                        epcN_q      <= pc_q;
                        causeN_q    <= bus.trap_cause;
                        trapTaken_q <= 1'b1;
                        busy_q      <= 1'b1;
                    end else if (bus.pc_write) begin
                        pc_q <= nxt_d;
                    end
                end
                TRAP: begin
                    state_q     <= RUN;
                    pc_q        <= TRAP_VECTOR;
                    epc_q       <= epcN_q;
                    cause_q     <= causeN_q;
                    trapTaken_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
                default: begin
                    state_q     <= BOOT;
                    trapTaken_q <= 1'b0;
                    busy_q      <= 1'b1;
                end
            endcase
        end
    end

    assign bus.pc         = pc_q;
    assign bus.old_pc     = oldPc_q;
    assign bus.pc_plus    = pc_q + XLEN'(IALIGN);
    assign bus.epc        = epc_q;
    assign bus.cause      = cause_q;
    assign bus.trap_taken = trapTaken_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_pc_unit.sv
// ---------------------------------------------------------------------------
// tb_pc_unit
// Self-checking bench for pc_unit. Three instances share one stimulus
// stream: the default configuration, one with RESET_VECTOR = 0x8000_0000,
// and one with IALIGN = 2. Expected values are queued when stimulus is
// applied and popped/compared one time unit after the following clock edge.
// ---------------------------------------------------------------------------
module tb_pc_unit;
    import pc_pkg::*;

    typedef enum int {
        SIG_PC, SIG_OLDPC, SIG_PCPLUS, SIG_EPC, SIG_CAUSE, SIG_TAKEN,
        SIG_BUSY, SIG_RV_PC, SIG_AL2_PC, SIG_AL2_TAKEN
    } sig_e;

    typedef struct {
        sig_e        sig;
        logic [31:0] value;
        string       tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        pcWrite;
    pc_src_e     pcSrc;
    logic [31:0] target;
    logic        irWrite;
    logic        trapReq;
    logic [3:0]  trapCause;

    int   vectors     = 0;
    int   miscompares = 0;
    exp_t expQ[$];

    pc_unit_if #(.XLEN(32), .CAUSE_W(4)) ifMain ();
    pc_unit_if #(.XLEN(32), .CAUSE_W(4)) ifRv ();
    pc_unit_if #(.XLEN(32), .CAUSE_W(4)) ifAl2 ();

    // All three instances see the same control stream.
    assign ifMain.pc_write   = pcWrite;
    assign ifMain.pc_src     = pcSrc;
    assign ifMain.target     = target;
    assign ifMain.ir_write   = irWrite;
    assign ifMain.trap_req   = trapReq;
    assign ifMain.trap_cause = trapCause;
    assign ifRv.pc_write     = pcWrite;
    assign ifRv.pc_src       = pcSrc;
    assign ifRv.target       = target;
    assign ifRv.ir_write     = irWrite;
    assign ifRv.trap_req     = trapReq;
    assign ifRv.trap_cause   = trapCause;
    assign ifAl2.pc_write    = pcWrite;
    assign ifAl2.pc_src      = pcSrc;
    assign ifAl2.target      = target;
    assign ifAl2.ir_write    = irWrite;
    assign ifAl2.trap_req    = trapReq;
    assign ifAl2.trap_cause  = trapCause;

    pc_unit #(
        .XLEN(32), .RESET_VECTOR(32'h0000_0000), .TRAP_VECTOR(32'h0000_0100),
        .IALIGN(4), .CAUSE_W(4)
    ) dutMain (.clk(clk), .rst(rst), .bus(ifMain));

    pc_unit #(
        .XLEN(32), .RESET_VECTOR(32'h8000_0000), .TRAP_VECTOR(32'h0000_0100),
        .IALIGN(4), .CAUSE_W(4)
    ) dutRv (.clk(clk), .rst(rst), .bus(ifRv));

    pc_unit #(
        .XLEN(32), .RESET_VECTOR(32'h0000_0000), .TRAP_VECTOR(32'h0000_0100),
        .IALIGN(2), .CAUSE_W(4)
    ) dutAl2 (.clk(clk), .rst(rst), .bus(ifAl2));

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    // Maps a scoreboard signal id onto the live DUT output it names.
    function automatic logic [31:0] observe(sig_e s);
        case (s)
            SIG_PC:        return ifMain.pc;
            SIG_OLDPC:     return ifMain.old_pc;
            SIG_PCPLUS:    return ifMain.pc_plus;
            SIG_EPC:       return ifMain.epc;
            SIG_CAUSE:     return 32'(ifMain.cause);
            SIG_TAKEN:     return 32'(ifMain.trap_taken);
            SIG_BUSY:      return 32'(ifMain.busy);
            SIG_RV_PC:     return ifRv.pc;
            SIG_AL2_PC:    return ifAl2.pc;
            SIG_AL2_TAKEN: return 32'(ifAl2.trap_taken);
            default:       return 32'hDEAD_BEEF;
        endcase
    endfunction

    // Single comparison point: counts every vector and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    // Drives every control input for the next clock edge.
    task automatic applyStimulus(input logic pw, input pc_src_e src,
                                 input logic [31:0] tgt, input logic irw,
                                 input logic treq, input logic [3:0] tc);
        pcWrite   = pw;
        pcSrc     = src;
        target    = tgt;
        irWrite   = irw;
        trapReq   = treq;
        trapCause = tc;
    endtask

    // Queues one expected output value.
    task automatic expectVal(input sig_e s, input logic [31:0] v,
                             input string tag);
        exp_t e;
        e.sig   = s;
        e.value = v;
        e.tag   = tag;
        expQ.push_back(e);
    endtask

    // Compares everything currently queued against the live outputs.
    task automatic drain();
        exp_t e;
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput(e.tag, observe(e.sig), e.value);
        end
    endtask

    // Advances one clock edge, then checks just after it.
    task automatic tick();
        @(posedge clk);
        #1;
        drain();
    endtask

    initial begin
        // Reset with pc_write forced high to show it has no effect.
        rst = 1'b1;
        applyStimulus(1'b1, PC_SEQ, 32'h0, 1'b0, 1'b0, 4'd0);
        expectVal(SIG_PC,    32'h0,         "rst_pc");
        expectVal(SIG_OLDPC, 32'h0,         "rst_oldpc");
        expectVal(SIG_EPC,   32'h0,         "rst_epc");
        expectVal(SIG_CAUSE, 32'h0,         "rst_cause");
        expectVal(SIG_TAKEN, 32'h0,         "rst_taken");
        expectVal(SIG_BUSY,  32'h1,         "rst_busy");
        expectVal(SIG_RV_PC, 32'h8000_0000, "rst_rv_pc");
        tick();

        // BOOT cycle: pc_write ignored, then RUN.
        rst = 1'b0;
        expectVal(SIG_PC,    32'h0,         "boot_pc_hold");
        expectVal(SIG_RV_PC, 32'h8000_0000, "boot_rv_pc_hold");
        expectVal(SIG_BUSY,  32'h0,         "boot_busy_drop");
        tick();

        // First RUN edge with SEQ.
        expectVal(SIG_PC,    32'h4,         "seq_pc");
        expectVal(SIG_RV_PC, 32'h8000_0004, "seq_rv_pc");
        tick();
        expectVal(SIG_PCPLUS, 32'h8, "pc_plus");
        drain();

        // Sequential wrap at the top of the address space.
        applyStimulus(1'b1, PC_TARGET, 32'hFFFF_FFFC, 1'b0, 1'b0, 4'd0);
        expectVal(SIG_PC, 32'hFFFF_FFFC, "wrap_setup");
        tick();
        expectVal(SIG_PCPLUS, 32'h0, "wrap_pc_plus");
        drain();
        applyStimulus(1'b1, PC_SEQ, 32'h0, 1'b0, 1'b0, 4'd0);
        expectVal(SIG_PC,    32'h0, "wrap_pc");
        expectVal(SIG_TAKEN, 32'h0, "wrap_no_trap");
        tick();

        // Misaligned jump: old_pc = 0x40, then TARGET 0x102.
        applyStimulus(1'b1, PC_TARGET, 32'h40, 1'b0, 1'b0, 4'd0);
        expectVal(SIG_PC, 32'h40, "mis_setup_pc");
        tick();
        applyStimulus(1'b0, PC_SEQ, 32'h0, 1'b1, 1'b0, 4'd0);
        expectVal(SIG_OLDPC, 32'h40, "mis_setup_oldpc");
        tick();
        applyStimulus(1'b1, PC_TARGET, 32'h102, 1'b0, 1'b0, 4'd0);
        expectVal(SIG_TAKEN,     32'h1,   "mis_taken");
        expectVal(SIG_BUSY,      32'h1,   "mis_busy");
        expectVal(SIG_PC,        32'h40,  "mis_pc_hold");
        expectVal(SIG_AL2_PC,    32'h102, "al2_pc");
        expectVal(SIG_AL2_TAKEN, 32'h0,   "al2_no_trap");
        tick();
        applyStimulus(1'b0, PC_SEQ, 32'h0, 1'b0, 1'b0, 4'd0);
        expectVal(SIG_PC,    32'h100, "mis_vec_pc");
        expectVal(SIG_EPC,   32'h40,  "mis_epc");
        expectVal(SIG_CAUSE, 32'h0,   "mis_cause");
        expectVal(SIG_TAKEN, 32'h0,   "mis_taken_end");
        expectVal(SIG_BUSY,  32'h0,   "mis_busy_end");
        tick();

        // JALR clears bit 0.
        applyStimulus(1'b1, PC_JALR, 32'h205, 1'b0, 1'b0, 4'd0);
        expectVal(SIG_PC,    32'h204, "jalr_pc");
        expectVal(SIG_TAKEN, 32'h0,   "jalr_no_trap");
        tick();

        // External trap, cause 11.
        applyStimulus(1'b0, PC_SEQ, 32'h0, 1'b0, 1'b1, 4'd11);
        expectVal(SIG_TAKEN, 32'h1,   "ext_taken");
        expectVal(SIG_PC,    32'h204, "ext_pc_hold");
        tick();
        applyStimulus(1'b0, PC_SEQ, 32'h0, 1'b0, 1'b0, 4'd0);
        expectVal(SIG_PC,    32'h100, "ext_vec_pc");
        expectVal(SIG_EPC,   32'h204, "ext_epc");
        expectVal(SIG_CAUSE, 32'd11,  "ext_cause");
        tick();

        // MRET returns to EPC.
        applyStimulus(1'b1, PC_MRET, 32'h0, 1'b0, 1'b0, 4'd0);
        expectVal(SIG_PC,    32'h204, "mret_pc");
        expectVal(SIG_TAKEN, 32'h0,   "mret_no_trap");
        tick();

        // Misaligned TARGET together with trap_req: misalignment wins.
        applyStimulus(1'b1, PC_TARGET, 32'h102, 1'b0, 1'b1, 4'd11);
        expectVal(SIG_TAKEN, 32'h1,   "both_taken");
        expectVal(SIG_PC,    32'h204, "both_pc_hold");
        tick();
        applyStimulus(1'b0, PC_SEQ, 32'h0, 1'b0, 1'b0, 4'd0);
        expectVal(SIG_CAUSE, 32'h0,   "both_cause");
        expectVal(SIG_EPC,   32'h40,  "both_epc");
        expectVal(SIG_PC,    32'h100, "both_vec_pc");
        tick();

        // trap_req with an aligned pc_write: the write is dropped.
        applyStimulus(1'b1, PC_TARGET, 32'h80, 1'b0, 1'b0, 4'd0);
        expectVal(SIG_PC, 32'h80, "drop_setup");
        tick();
        applyStimulus(1'b1, PC_TARGET, 32'h300, 1'b0, 1'b1, 4'd3);
        expectVal(SIG_TAKEN, 32'h1,  "drop_taken");
        expectVal(SIG_PC,    32'h80, "drop_pc_hold");
        tick();
        applyStimulus(1'b0, PC_SEQ, 32'h0, 1'b0, 1'b0, 4'd0);
        expectVal(SIG_PC,    32'h100, "drop_vec_pc");
        expectVal(SIG_EPC,   32'h80,  "drop_epc");
        expectVal(SIG_CAUSE, 32'd3,   "drop_cause");
        tick();

        // ir_write with pc_write: old_pc gets the pre-update pc.
        applyStimulus(1'b1, PC_TARGET, 32'h180, 1'b1, 1'b0, 4'd0);
        expectVal(SIG_OLDPC, 32'h100, "irw_oldpc");
        expectVal(SIG_PC,    32'h180, "irw_pc");
        tick();

        // trap_req held: TRAP and RUN alternate.
        applyStimulus(1'b0, PC_SEQ, 32'h0, 1'b0, 1'b1, 4'd7);
        expectVal(SIG_TAKEN, 32'h1, "held_taken_1");
        tick();
        expectVal(SIG_TAKEN, 32'h0,   "held_run_1");
        expectVal(SIG_EPC,   32'h180, "held_epc_1");
        expectVal(SIG_CAUSE, 32'd7,   "held_cause_1");
        tick();
        expectVal(SIG_TAKEN, 32'h1, "held_taken_2");
        tick();
        expectVal(SIG_TAKEN, 32'h0,   "held_run_2");
        expectVal(SIG_EPC,   32'h100, "held_epc_2");
        tick();

        // Reset asserted during TRAP aborts the trap.
        applyStimulus(1'b0, PC_SEQ, 32'h0, 1'b0, 1'b1, 4'd5);
        expectVal(SIG_TAKEN, 32'h1, "rtrap_taken");
        tick();
        rst = 1'b1;
        applyStimulus(1'b0, PC_SEQ, 32'h0, 1'b0, 1'b0, 4'd0);
        expectVal(SIG_PC,    32'h0, "rtrap_pc");
        expectVal(SIG_OLDPC, 32'h0, "rtrap_oldpc");
        expectVal(SIG_EPC,   32'h0, "rtrap_epc");
        expectVal(SIG_CAUSE, 32'h0, "rtrap_cause");
        expectVal(SIG_TAKEN, 32'h0, "rtrap_taken_clr");
        expectVal(SIG_BUSY,  32'h1, "rtrap_busy");
        tick();
        rst = 1'b0;
        expectVal(SIG_PC,   32'h0, "rtrap_boot_pc");
        expectVal(SIG_BUSY, 32'h0, "rtrap_boot_done");
        tick();

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the multicycle RV32I core; the next generation of the plain PC register. It holds the PC and, under control of the main FSM, selects the next PC from one of four sources: sequential, branch/JAL target, JALR target, or MRET return. It also captures the PC of the instruction being fetched into an `old_pc` register. It detects misaligned control-flow targets, sequences a one-cycle trap redirect to a trap vector with EPC/cause capture, and holds a boot cycle after reset.

## Interface
Parameters:
- `XLEN`, 32: PC and data width.
- `RESET_VECTOR`, 32'h0000_0000: PC value after reset.
- `TRAP_VECTOR`, 32'h0000_0100: PC loaded on any trap. Must be IALIGN-aligned.
- `IALIGN`, 4: instruction alignment in bytes. Only 4 or 2 are legal. It is also the sequential increment.
- `CAUSE_W`, 4: width of the cause field.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset. Synchronous, active-high.
- `pc_write` in 1: update PC this cycle.
- `pc_src` in 2: next-PC select. 0 = SEQ, 1 = TARGET, 2 = JALR, 3 = MRET.
- `target` in XLEN: computed target address (ALU result).
- `ir_write` in 1: fetch strobe. Latches `pc` into `old_pc`.
- `trap_req` in 1: external trap request, level-sensitive.
- `trap_cause` in CAUSE_W: cause for `trap_req`.
- `pc` out XLEN: current PC.
- `old_pc` out XLEN: PC of the instruction in IR.
- `pc_plus` out XLEN: `pc + IALIGN`, combinational. Used as the link value.
- `epc` out XLEN: exception PC.
- `cause` out CAUSE_W: latched trap cause.
- `trap_taken` out 1: one-cycle pulse while in TRAP.
- `busy` out 1: high in BOOT and TRAP. The core FSM stalls while it is high.

## Operation
- State machine: BOOT, RUN, TRAP.
  - `rst` high forces BOOT at the next edge.
  - BOOT always moves to RUN after one cycle.
  - TRAP always moves to RUN after one cycle.
- Next-PC candidate `nxt`:
  - SEQ: `pc + IALIGN`, modulo 2^XLEN (wraps silently).
  - TARGET: `target`.
  - JALR: `target` with bit 0 cleared.
  - MRET: `epc`.
- Misaligned condition: `mis = pc_write && (nxt mod IALIGN != 0)`, evaluated in RUN only.
- Priority in RUN, highest first:
  1. `mis`: go to TRAP with `cause_n = 0` (MISALIGNED), `epc_n = old_pc`. `pc` is not updated.
  2. `trap_req`: go to TRAP with `cause_n = trap_cause`, `epc_n = pc`. `pc_write` is ignored.
  3. `pc_write`: `pc <= nxt`.
- TRAP cycle:
  - `pc <= TRAP_VECTOR`; `epc` and `cause` are loaded from the values captured on the RUN→TRAP edge.
  - `trap_taken = 1`; `pc_write` and `trap_req` are ignored.
- BOOT: `pc_write` and `trap_req` are ignored. `pc` stays at RESET_VECTOR.
- `ir_write` is honoured in any state except BOOT. It is independent of `pc_write`, so with both active `old_pc` receives the pre-update `pc`.
- MRET with an aligned `epc` never traps. `epc` is always aligned by construction.

## Timing
- Reset values:
  - `pc` = RESET_VECTOR, `old_pc` = RESET_VECTOR.
  - `epc` = 0, `cause` = 0.
  - `trap_taken` = 0, `busy` = 1 (state BOOT).
- `pc_write` latency: the new `pc` is visible one cycle after the edge on which `pc_write` is sampled.
- Trap latency: request sampled at edge N. TRAP state is entered at N; `pc` = TRAP_VECTOR and `epc`/`cause` are valid after edge N+1. `trap_taken` is high between edges N and N+1.
- `pc_plus` follows `pc` combinationally with zero latency.
- `rst` asserted mid-TRAP: the trap is aborted, all registers take reset values, and `epc`/`cause` are not updated.
- `trap_req` held high continuously: one trap is taken per RUN cycle, so TRAP and RUN alternate.

## Structure
- Package `pc_pkg`:
  - state enum {BOOT, RUN, TRAP};
  - `pc_src` encodings PC_SEQ, PC_TARGET, PC_JALR, PC_MRET;
  - CAUSE_MISALIGNED = 0.
- One combinational sub-module, `pc_next_sel`: computes `nxt` and `mis` from `pc`, `target`, `epc`, `pc_src` and IALIGN.
- The top level holds the FSM and the registers.

## Test plan
- Reset and boot, with `pc_write` = 1 forced: `pc` = 0 in BOOT, `busy` = 1. The first RUN edge with SEQ gives `pc` = 4. Check again with RESET_VECTOR = 32'h8000_0000, which gives `pc` = 32'h8000_0004.
- Sequential wrap: `pc` = 32'hFFFF_FFFC, SEQ write → `pc` = 0, no trap.
- Misaligned jump:
  - Setup: `old_pc` = 32'h40, TARGET with `target` = 32'h102, IALIGN = 4.
  - Required: `trap_taken` pulses, then `pc` = 32'h100, `epc` = 32'h40, `cause` = 0.
  - The same stimulus with IALIGN = 2 gives `pc` = 32'h102 and no trap.
- JALR and MRET:
  - JALR with `target` = 32'h205 → `pc` = 32'h204.
  - Then `trap_req` with `trap_cause` = 11 → `epc` = 32'h204, `pc` = 32'h100.
  - MRET → `pc` = 32'h204.
- Simultaneous events:
  - Misaligned TARGET together with `trap_req` (cause 11) → `cause` = 0.
  - `trap_req` together with an aligned `pc_write` → the PC write is dropped, `epc` = the pre-write `pc`.
- Reset during TRAP: assert `rst` in the TRAP cycle → next state BOOT, `pc` = RESET_VECTOR, `epc` = 0, `cause` = 0.
